// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the serial console receiver.
//   uart_state_e   - receiver FSM states
//   ASCII_LF       - line terminator reported through line_done
//   clks_per_bit() - clock cycles per serial bit (integer division)
//   even_parity()  - XOR reduction of a data byte
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous rx line.
// Ports:
//   clk_in - system clock
//   reset  - synchronous active-high reset (flops reset to 1 = line idle)
//   d_in   - asynchronous input
//   d_out  - synchronized output
module uart_rx_sync (
  input  logic clk_in,
  input  logic reset,
  input  logic d_in,
  output logic d_out
);

  logic [1:0] sync_d;
  logic [1:0] sync_q;

  // Shift the raw line through the two-stage chain.
  always_comb begin
    sync_d = {sync_q[0], d_in};
  end

  // Synchronizer flops; reset to the idle-high line level.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign d_out = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 (optional even parity) serial receiver / console monitor.
// Ports:
//   clk_in     - system clock
//   reset      - synchronous active-high reset
//   rx         - asynchronous serial line, idle high
//   rx_en      - receive enable; dropping it mid-frame aborts the frame
//   data       - last received byte, held until the next word_done
//   word_done  - one-cycle strobe, data and status valid
//   parity_err - even-parity mismatch on the reported byte
//   frame_err  - stop bit sampled low on the reported byte
//   line_done  - one-cycle strobe with word_done when data is LF
//   byte_count - bytes reported since reset, wrapping
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 8000000,
  parameter int BAUD_RATE   = 38400,
  parameter bit PARITY_EN   = 1'b0
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        rx,
  input  logic        rx_en,
  output logic [7:0]  data,
  output logic        word_done,
  output logic        parity_err,
  output logic        frame_err,
  output logic        line_done,
  output logic [15:0] byte_count
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  logic              rx_s;
  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_bad_q, par_bad_d;
  logic [7:0]        data_q, data_d;
  logic              word_done_q, word_done_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              line_done_q, line_done_d;
  logic [15:0]       byte_count_q, byte_count_d;
  logic              mid_bit_s;
  logic              frame_done_s;

  uart_rx_sync u_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .d_in   (rx),
    .d_out  (rx_s)
  );

  // After the start bit is centred, every full bit period lands mid-bit.
  assign mid_bit_s    = (cnt_q == CNT_LAST);
  assign frame_done_s = (state_q == STOP) && mid_bit_s && rx_en;

  // State and datapath registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_bad_q    <= 1'b0;
      data_q       <= 8'h00;
      word_done_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      line_done_q  <= 1'b0;
      byte_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      data_q       <= data_d;
      word_done_q  <= word_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      line_done_q  <= line_done_d;
      byte_count_q <= byte_count_d;
    end
  end

  // Next-state, bit timing and shift register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    if (!rx_en && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rx_en && !rx_s) begin
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          // Re-check the line half a bit in; a high level means a glitch.
          if (cnt_q == CNT_HALF) begin
            cnt_d     = '0;
            bit_idx_d = 3'd0;
            par_bad_d = 1'b0;
            state_d   = rx_s ? IDLE : DATA;
          end else begin
            state_d = START;
          end
        end
        DATA: begin
          if (mid_bit_s) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_d = PARITY_EN ? PARITY : STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            state_d = DATA;
          end
        end
        PARITY: begin
          if (mid_bit_s) begin
            cnt_d     = '0;
            par_bad_d = rx_s ^ even_parity(shift_q);
            state_d   = STOP;
          end else begin
            state_d = PARITY;
          end
        end
        STOP: begin
          // A low stop bit parks the FSM until the line returns high.
          if (mid_bit_s) begin
            cnt_d   = '0;
            state_d = rx_s ? IDLE : BREAK;
          end else begin
            state_d = STOP;
          end
        end
        BREAK: begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = BREAK;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Registered outputs: strobes and status are live for one cycle only.
  always_comb begin
    data_d       = data_q;
    byte_count_d = byte_count_q;
    word_done_d  = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    line_done_d  = 1'b0;
    if (frame_done_s) begin
      word_done_d  = 1'b1;
      data_d       = shift_q;
      parity_err_d = PARITY_EN & par_bad_q;
      frame_err_d  = ~rx_s;
      line_done_d  = (shift_q == ASCII_LF);
      byte_count_d = byte_count_q + 16'd1;
    end else begin
      word_done_d = 1'b0;
    end
  end

  assign data       = data_q;
  assign word_done  = word_done_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign line_done  = line_done_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Two instances share clock, reset
// and rx_en: dut0 is 8N1, dut1 has even parity enabled. Each has its own line.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 208;
  // Start-edge drive to visible strobe: 2 sync flops + half bit + 9 bits + 1.
  localparam int LAT = 2 + 104 + 9 * CPB + 1;

  typedef struct {
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    logic        ld;
    logic [15:0] cnt;
    int          t0;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic rx_en = 1'b1;

  logic [7:0]  data0, data1;
  logic        wd0, wd1, pe0, pe1, fe0, fe1, ld0, ld1;
  logic [15:0] bc0, bc1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [15:0] cnt0 = 16'd0;
  logic [15:0] cnt1 = 16'd0;
  logic prev_wd0 = 1'b0;
  logic prev_wd1 = 1'b0;

  uart_rx #(.CLK_FREQ_HZ(8000000), .BAUD_RATE(38400), .PARITY_EN(1'b0)) dut0 (
    .clk_in(clk), .reset(reset), .rx(rx0), .rx_en(rx_en),
    .data(data0), .word_done(wd0), .parity_err(pe0), .frame_err(fe0),
    .line_done(ld0), .byte_count(bc0)
  );

  uart_rx #(.CLK_FREQ_HZ(8000000), .BAUD_RATE(38400), .PARITY_EN(1'b1)) dut1 (
    .clk_in(clk), .reset(reset), .rx(rx1), .rx_en(rx_en),
    .data(data1), .word_done(wd1), .parity_err(pe1), .frame_err(fe1),
    .line_done(ld1), .byte_count(bc1)
  );

  always #62.5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic on_strobe(input int w, input logic [7:0] d, input logic pe,
                           input logic fe, input logic ld, input logic [15:0] bc);
    exp_t e;
    int lat;
    checks++;
    if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
      failures++;
      $display("FAIL unexpected_strobe dut%0d actual data=0x%0h required no strobe (cycle %0d)", w, d, cyc);
    end else begin
      if (w == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("dut%0d_data", w), int'(d), int'(e.d));
      chk($sformatf("dut%0d_parity_err", w), int'(pe), int'(e.pe));
      chk($sformatf("dut%0d_frame_err", w), int'(fe), int'(e.fe));
      chk($sformatf("dut%0d_line_done", w), int'(ld), int'(e.ld));
      chk($sformatf("dut%0d_byte_count", w), int'(bc), int'(e.cnt));
      lat = cyc - e.t0;
      checks++;
      if (lat < e.lat - 1 || lat > e.lat + 1) begin
        failures++;
        $display("FAIL dut%0d_latency actual=%0d required=%0d", w, lat, e.lat);
      end
    end
  endtask

  // Monitor: compare each strobe with the scoreboard; status must drop after it.
  always @(negedge clk) begin
    if (wd0) on_strobe(0, data0, pe0, fe0, ld0, bc0);
    if (wd1) on_strobe(1, data1, pe1, fe1, ld1, bc1);
    if (prev_wd0) chk("dut0_status_after_strobe", int'({wd0, pe0, fe0, ld0}), 0);
    if (prev_wd1) chk("dut1_status_after_strobe", int'({wd1, pe1, fe1, ld1}), 0);
    prev_wd0 <= wd0;
    prev_wd1 <= wd1;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic v);
    if (w == 0) rx0 = v;
    else        rx1 = v;
    idle(CPB);
  endtask

  // Serialize one frame; dut1's line carries a parity bit. Expected result is
  // pushed up front when the frame should be reported.
  task automatic send(input int w, input logic [7:0] b, input logic par,
                      input logic stop, input bit exp_on);
    exp_t e;
    bit with_par;
    with_par = (w == 1);
    if (exp_on) begin
      if (w == 0) begin cnt0 = cnt0 + 16'd1; e.cnt = cnt0; end
      else        begin cnt1 = cnt1 + 16'd1; e.cnt = cnt1; end
      e.d   = b;
      e.pe  = with_par ? (par != ^b) : 1'b0;
      e.fe  = ~stop;
      e.ld  = (b == 8'h0A);
      e.t0  = cyc;
      e.lat = LAT + (with_par ? CPB : 0);
      if (w == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    drive(w, 1'b0);
    for (int i = 0; i < 8; i++) drive(w, b[i]);
    if (with_par) drive(w, par);
    drive(w, stop);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_data"}, int'(data0), 0);
    chk({tag, "_word_done"}, int'(wd0), 0);
    chk({tag, "_parity_err"}, int'(pe0), 0);
    chk({tag, "_frame_err"}, int'(fe0), 0);
    chk({tag, "_line_done"}, int'(ld0), 0);
    chk({tag, "_byte_count"}, int'(bc0), 0);
    chk({tag, "_dut1_byte_count"}, int'(bc1), 0);
  endtask

  initial begin
    logic [7:0] b;
    logic       s;
    logic       p;

    idle(5);
    reset = 1'b0;
    chk_reset_state("reset");
    idle(20);

    // Short low pulse: glitch rejected at the half-bit check.
    rx0 = 1'b0;
    idle(50);
    rx0 = 1'b1;
    idle(400);
    chk("glitch_byte_count", int'(bc0), 0);

    send(0, 8'h38, 1'b0, 1'b1, 1'b1);
    idle(300);

    // Framing error, then line held low: nothing more until release.
    send(0, 8'h55, 1'b0, 1'b0, 1'b1);
    idle(500);
    rx0 = 1'b1;
    idle(20);
    send(0, 8'h41, 1'b0, 1'b1, 1'b1);
    idle(50);

    // Back-to-back "Hi\n" with no idle gap.
    send(0, 8'h48, 1'b0, 1'b1, 1'b1);
    send(0, 8'h69, 1'b0, 1'b1, 1'b1);
    send(0, 8'h0A, 1'b0, 1'b1, 1'b1);
    idle(300);
    chk("line_byte_count", int'(bc0), int'(cnt0));

    // Receiver disabled for a whole frame.
    rx_en = 1'b0;
    send(0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(10);
    rx_en = 1'b1;
    idle(20);
    chk("rx_en_off_byte_count", int'(bc0), int'(cnt0));

    // Reset during data bit 4 of 8'hF0 (remaining bits high, no false start).
    fork
      send(0, 8'hF0, 1'b0, 1'b1, 1'b0);
      begin
        idle(CPB * 5 + 100);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        cnt0 = 16'd0;
        cnt1 = 16'd0;
        chk_reset_state("midframe_reset");
      end
    join
    idle(50);
    send(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    idle(100);

    // Random 8N1 traffic, occasional framing errors.
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send(0, b, 1'b0, s, 1'b1);
      if (!s) begin
        idle($urandom_range(0, 100));
        rx0 = 1'b1;
        idle(5);
      end else begin
        idle($urandom_range(0, 150));
      end
    end

    // Even parity on the parity-enabled instance.
    send(1, 8'h07, 1'b1, 1'b1, 1'b1);
    idle(50);
    send(1, 8'h07, 1'b0, 1'b1, 1'b1);
    idle(50);
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      p = 1'($urandom_range(0, 1));
      send(1, b, p, 1'b1, 1'b1);
      idle($urandom_range(0, 100));
    end

    idle(100);
    chk("dut0_missing_strobes", q0.size(), 0);
    chk("dut1_missing_strobes", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Synthesizable serial receiver, 8N1 with optional parity, and the serial-console monitor for the Didactic SoC UART TX line.
- Samples the asynchronous rx line and reconstructs bytes LSB-first.
- Reports each completed byte with a one-cycle strobe plus parity/framing status and newline detection.
- Sits beside the SoC top in simulation and on FPGA test boards, so bring-up SW "print" output can be checked.

Parameters:
- CLK_FREQ_HZ, 8000000, frequency of clk_in (125 ns period).
- BAUD_RATE, 38400, bit rate.
- PARITY_EN, 0, 1 = one even-parity bit between data and stop.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD_RATE (integer division = 208), derived localparam, not overridable.

Ports:
- clk_in  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line, idle high
- rx_en  input  1  receive enable
- data  output  8  last received byte, held until next word_done
- word_done  output  1  one-cycle strobe: byte complete, data/status valid
- parity_err  output  1  parity mismatch on the reported byte (0 if PARITY_EN=0)
- frame_err  output  1  stop bit sampled 0 on the reported byte
- line_done  output  1  one-cycle strobe, coincident with word_done when data==8'h0A
- byte_count  output  16  bytes reported since reset; wraps 16'hFFFF->0

Behaviour:
- All logic clocked on clk_in rising edge. Reset is synchronous, active-high, one clock and one reset domain.
- Reset values: state IDLE, sync flops 1, data 0, word_done 0, parity_err 0, frame_err 0, line_done 0, byte_count 0.
- rx passes through a 2-flop synchronizer before any use; all latencies below count from the synchronized value.
- Bit counter cnt counts 0..CLKS_PER_BIT-1. HALF = CLKS_PER_BIT/2 = 104.
- State machine:
  - IDLE: if rx_en=1 and rx_s=0, go to START with cnt=0.
  - START: when cnt reaches HALF-1, resample. If rx_s=0, go to DATA with cnt=0 and bit index 0. If rx_s=1 (glitch), return to IDLE with no outputs.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit) into shift register, LSB first. After bit 7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: sample at mid-bit; parity_err_next = sampled bit XOR (^data bits), i.e. even parity.
  - STOP: sample at mid-bit. On the next cycle, pulse word_done, update data and byte_count, and set frame_err = ~stop bit. line_done = (byte==8'h0A).
    - Stop bit 1: go to IDLE.
    - Stop bit 0: go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. No new frame can start while the line is held low.
- parity_err/frame_err are only meaningful while word_done=1. Drive them to 0 in the cycle after the strobe.
- word_done is asserted even on errors; consumers qualify it with the error flags.
- rx_en=0 in any non-IDLE state aborts to IDLE on the next cycle, with no strobe and data unchanged.
- Reset mid-frame returns to IDLE immediately and clears everything.
- Back-to-back frames: a start edge detected in the cycle the FSM returns to IDLE is accepted. No gap beyond the stop bit is required.
- Latency: word_done is at start-edge(sync) + HALF + 9*CLKS_PER_BIT (+CLKS_PER_BIT with parity) + 1 cycles.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP, BREAK}
  - ASCII_LF = 8'h0A
  - function clks_per_bit(freq, baud)
- One natural sub-module: uart_rx_sync, the 2-flop synchronizer with reset value 1. The FSM, counter and shift register stay in uart_rx.

Test Plan:
- Defaults, send 8'h38 as 8N1 at 208 clks/bit -> exactly one word_done about 1976+3 cycles after the falling edge; data=8'h38, parity_err=0, frame_err=0, byte_count=1.
- rx low for 50 cycles then high (glitch) -> no word_done, FSM back in IDLE, byte_count=0.
- Send 8'h55 with stop bit driven 0, then hold low 500 cycles, then release and send 8'h41 -> first strobe with frame_err=1, data=8'h55; no strobe during low hold; second strobe data=8'h41, frame_err=0.
- PARITY_EN=1: send 8'h07 with parity bit 1 -> parity_err=0; send 8'h07 with parity bit 0 -> parity_err=1.
- Back-to-back "H","i",8'h0A with no idle gap -> three word_done strobes; line_done only on the third; byte_count=3.
- rx_en=0 during a full frame -> no strobe. Then rx_en=1, assert reset at bit 4 of a frame -> outputs 0 and IDLE; a following 8'hA5 is received correctly.
